// File: rtl/chroni_text_fetch.sv
// Text-mode fetch scheduler: sequences code and glyph reads on the shared
// 2-cycle memory port, serialises glyph bytes to pixels, and slots in CPU reads.
module chroni_text_fetch #(
  parameter int MEM_AW         = 14,
  parameter int COLS           = 100,
  parameter int FONT_ROWS_LOG2 = 3,
  parameter int TEXT_BASE      = 0,
  parameter int FONT_BASE      = 8192
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              line_start,
  input  logic [9:0]        line_row,
  output logic              mem_rd,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [7:0]        mem_q,
  input  logic              cpu_req,
  input  logic [MEM_AW-1:0] cpu_addr,
  output logic              cpu_ack,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_rdata_valid,
  output logic              pix_out,
  output logic              pix_valid,
  output logic              busy,
  output logic              line_overrun
);

  localparam int COL_W = $clog2(COLS + 1);

  typedef enum logic [1:0] {IDLE, FETCH, LAST} state_t;
  typedef enum logic [1:0] {TAG_NONE, TAG_CODE, TAG_GLYPH, TAG_CPU} tag_t;

  state_t                    state, state_nxt;
  logic [2:0]                slot;
  logic [COL_W-1:0]          col;
  logic [MEM_AW-1:0]         line_base;
  logic [FONT_ROWS_LOG2-1:0] glyph_row;
  logic [9:0]                text_row;
  tag_t                      tag_now, tag_p1, tag_p2;
  logic [7:0]                code;
  logic [7:0]                glyph_next;
  logic [7:0]                shift;
  logic [7:0]                rdata_hold;
  logic                      start;
  logic                      disp_rd;
  logic [MEM_AW-1:0]         disp_addr;
  tag_t                      disp_tag;
  logic                      cpu_slot;

  assign text_row = line_row >> FONT_ROWS_LOG2;
  // The code byte is only trusted when the returning read was tagged as a code fetch.
  assign code     = (tag_p2 == TAG_CODE) ? mem_q : 8'h00;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    disp_rd   = 1'b0;
    disp_addr = '0;
    disp_tag  = TAG_NONE;
    cpu_slot  = 1'b0;
    case (state)
      IDLE: begin
        if (line_start) begin
          state_nxt = FETCH;
          start     = 1'b1;
        end else begin
          cpu_slot = 1'b1;
        end
      end
      FETCH: begin
        if (slot == 3'd0) begin
          disp_rd   = 1'b1;
          disp_addr = line_base + MEM_AW'(col);
          disp_tag  = TAG_CODE;
        end else if (slot == 3'd2) begin
          disp_rd   = 1'b1;
          disp_addr = MEM_AW'(FONT_BASE) + (MEM_AW'(code) << FONT_ROWS_LOG2)
                      + MEM_AW'(glyph_row);
          disp_tag  = TAG_GLYPH;
        end
        cpu_slot = (slot == 3'd4) || (slot == 3'd6);
        if (slot == 3'd7 && col == COL_W'(COLS - 1)) state_nxt = LAST;
      end
      LAST: begin
        cpu_slot = ~slot[0];
        if (slot == 3'd7) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign cpu_ack   = cpu_slot & cpu_req & ~reset;
  assign mem_rd    = disp_rd | cpu_ack;
  assign mem_addr  = cpu_ack ? cpu_addr : disp_addr;
  assign tag_now   = cpu_ack ? TAG_CPU : disp_tag;

  assign busy      = (state != IDLE);
  assign pix_valid = ((state == FETCH) && (col != '0)) || (state == LAST);
  assign pix_out   = pix_valid & shift[7];

  assign cpu_rdata_valid = (tag_p2 == TAG_CPU);
  assign cpu_rdata       = cpu_rdata_valid ? mem_q : rdata_hold;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot         <= '0;
      col          <= '0;
      line_base    <= '0;
      glyph_row    <= '0;
      line_overrun <= 1'b0;
      tag_p1       <= TAG_NONE;
      tag_p2       <= TAG_NONE;
      glyph_next   <= '0;
      shift        <= '0;
      rdata_hold   <= '0;
    end else begin
      // Stage p1 -> p2: tags follow each read until its data is on mem_q
      tag_p1 <= tag_now;
      tag_p2 <= tag_p1;
      if (line_start && state != IDLE) line_overrun <= 1'b1;
      if (start) begin
        slot      <= '0;
        col       <= '0;
        line_base <= MEM_AW'(TEXT_BASE) + MEM_AW'(int'(text_row) * COLS);
        glyph_row <= line_row[FONT_ROWS_LOG2-1:0];
      end else if (state != IDLE) begin
        slot <= slot + 3'd1;
        if (state == FETCH && slot == 3'd7) col <= col + 1'b1;
      end
      // Stage p2: route returned data by tag
      if (tag_p2 == TAG_GLYPH) glyph_next <= mem_q;
      if (tag_p2 == TAG_CPU)   rdata_hold <= mem_q;
      if (state == FETCH && slot == 3'd7) shift <= glyph_next;
      else                                shift <= {shift[6:0], 1'b0};
    end
  end

endmodule

// File: tb/tb_chroni_text_fetch.sv
// Scoreboard bench for chroni_text_fetch: stimulus pushes expected events,
// a negedge monitor pops and compares them against the DUT.
module tb_chroni_text_fetch;
  localparam int AW = 14;

  typedef struct {
    int cyc;
    int v;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          line_start = 1'b0;
  logic [9:0]    line_row = '0;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_q;
  logic          cpu_req = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic          cpu_ack;
  logic [7:0]    cpu_rdata;
  logic          cpu_rdata_valid;
  logic          pix_out, pix_valid, busy, line_overrun;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  logic [7:0] mem [0:16383];
  logic [7:0] q1;

  exp_t rd_q[$], pix_q[$], ack_q[$], rdv_q[$], flag_q[$];

  chroni_text_fetch dut (
    .clk(clk), .reset(reset), .line_start(line_start), .line_row(line_row),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_q(mem_q),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_ack(cpu_ack),
    .cpu_rdata(cpu_rdata), .cpu_rdata_valid(cpu_rdata_valid),
    .pix_out(pix_out), .pix_valid(pix_valid), .busy(busy),
    .line_overrun(line_overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // memory with exactly two cycles of read latency
  always @(posedge clk) begin
    q1    <= mem_rd ? mem[mem_addr] : 8'hEE;
    mem_q <= q1;
  end

  task automatic chk(input bit ok, input string nm, input int act, input int expv);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", nm, cyc, act, expv);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    exp_t e;
    int z;
    while (rd_q.size() > 0 && rd_q[0].cyc < cyc) begin
      e = rd_q.pop_front(); chk(1'b0, "rd_missing", -1, e.v);
    end
    while (pix_q.size() > 0 && pix_q[0].cyc < cyc) begin
      e = pix_q.pop_front(); chk(1'b0, "pix_missing", -1, e.v);
    end
    while (ack_q.size() > 0 && ack_q[0].cyc < cyc) begin
      e = ack_q.pop_front(); chk(1'b0, "ack_missing", -1, e.v);
    end
    while (rdv_q.size() > 0 && rdv_q[0].cyc < cyc) begin
      e = rdv_q.pop_front(); chk(1'b0, "rdata_missing", -1, e.v);
    end
    while (flag_q.size() > 0 && flag_q[0].cyc < cyc) begin
      e = flag_q.pop_front(); chk(1'b0, "flag_missing", -1, e.v);
    end

    if (mem_rd) begin
      if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
        e = rd_q.pop_front(); chk(int'(mem_addr) == e.v, "rd_addr", int'(mem_addr), e.v);
      end else chk(1'b0, "rd_unexpected", int'(mem_addr), -1);
    end

    if (pix_valid) begin
      if (pix_q.size() > 0 && pix_q[0].cyc == cyc) begin
        e = pix_q.pop_front(); chk(int'(pix_out) == e.v, "pix_out", int'(pix_out), e.v);
      end else chk(1'b0, "pix_valid_unexpected", 1, 0);
    end else begin
      chk(pix_out == 1'b0, "pix_out_idle", int'(pix_out), 0);
    end

    if (cpu_ack) begin
      if (ack_q.size() > 0 && ack_q[0].cyc == cyc) begin
        e = ack_q.pop_front(); chk(int'(mem_addr) == e.v, "cpu_ack_addr", int'(mem_addr), e.v);
      end else chk(1'b0, "cpu_ack_unexpected", int'(cpu_addr), -1);
    end

    if (cpu_rdata_valid) begin
      if (rdv_q.size() > 0 && rdv_q[0].cyc == cyc) begin
        e = rdv_q.pop_front(); chk(int'(cpu_rdata) == e.v, "cpu_rdata", int'(cpu_rdata), e.v);
      end else chk(1'b0, "cpu_rdata_valid_unexpected", int'(cpu_rdata), -1);
    end

    if (flag_q.size() > 0 && flag_q[0].cyc == cyc) begin
      e = flag_q.pop_front();
      if (e.v[2]) begin
        z = int'({mem_rd, cpu_ack, cpu_rdata_valid, pix_out, pix_valid, busy,
                  line_overrun, (mem_addr != '0), (cpu_rdata != 8'h00)});
        chk(z == 0, "reset_outputs_zero", z, 0);
      end else begin
        chk(int'(busy) == int'(e.v[1]), "busy", int'(busy), int'(e.v[1]));
        chk(int'(line_overrun) == int'(e.v[0]), "line_overrun", int'(line_overrun), int'(e.v[0]));
      end
    end
  end

  function automatic void rd_ins(input int c, input int a);
    int i;
    exp_t e;
    e = '{c, a};
    i = 0;
    while (i < rd_q.size() && rd_q[i].cyc < c) i++;
    rd_q.insert(i, e);
  endfunction

  function automatic void push_line(input int t, input int row);
    int lb, g, a, ga;
    logic [7:0] gb;
    lb = (row >> 3) * 100;
    g  = row & 7;
    for (int c = 0; c < 100; c++) begin
      a  = (lb + c) & 16383;
      ga = (8192 + int'(mem[a]) * 8 + g) & 16383;
      gb = mem[ga];
      rd_ins(t + 1 + 8 * c, a);
      rd_ins(t + 3 + 8 * c, ga);
      for (int b = 0; b < 8; b++) pix_q.push_back('{t + 9 + 8 * c + b, int'(gb[7 - b])});
    end
  endfunction

  task automatic start_line(input int row, input bit push, output int t);
    line_row   = 10'(row);
    line_start = 1'b1;
    t = cyc;
    if (push) push_line(t, row);
    @(posedge clk); #1;
    line_start = 1'b0;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_ack_drop();
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (cpu_ack) break;
    end
    @(posedge clk); #1;
    cpu_req = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((rd_q.size() + pix_q.size() + ack_q.size() + rdv_q.size() + flag_q.size()) > 0
           && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 2000) begin
      $display("FAIL drain_timeout cyc=%0d", cyc);
      $fatal(1, "scoreboard did not drain");
    end
  endtask

  initial begin
    int t, k;
    for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
    mem[0]    = 8'h41;  mem[1]    = 8'h42;
    mem[8712] = 8'hA5;  mem[8720] = 8'h3C;  mem[8192] = 8'h18;
    mem[100]  = 8'h02;  mem[101]  = 8'h41;
    mem[8213] = 8'h81;  mem[8717] = 8'hF0;  mem[8197] = 8'h66;
    mem[500]  = 8'h3C;  mem[77]   = 8'h5A;
    mem[10] = 8'h11; mem[11] = 8'h22; mem[12] = 8'h33; mem[13] = 8'h44;

    // reset state
    @(posedge clk); #1;
    flag_q.push_back('{cyc, 4});
    flag_q.push_back('{cyc + 1, 4});
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    flag_q.push_back('{cyc, 0});
    repeat (3) begin @(posedge clk); #1; end

    // glyph serialisation, row 0
    start_line(0, 1'b1, t);
    flag_q.push_back('{t + 808, 2});
    flag_q.push_back('{t + 810, 0});
    wait_drain();
    repeat (4) begin @(posedge clk); #1; end

    // back-to-back CPU reads while idle
    k = cyc;
    cpu_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cpu_addr = AW'(10 + i);
      ack_q.push_back('{k + i, 10 + i});
      rd_ins(k + i, 10 + i);
      rdv_q.push_back('{k + i + 2, int'(mem[10 + i])});
      @(posedge clk); #1;
    end
    cpu_req = 1'b0;
    wait_drain();
    repeat (4) begin @(posedge clk); #1; end

    // row 13 addressing, CPU read inside the line, overrun
    start_line(13, 1'b1, t);
    cpu_req  = 1'b1;
    cpu_addr = AW'(500);
    ack_q.push_back('{t + 5, 500});
    rd_ins(t + 5, 500);
    rdv_q.push_back('{t + 7, 8'h3C});
    flag_q.push_back('{t + 99, 2});
    flag_q.push_back('{t + 101, 3});
    flag_q.push_back('{t + 810, 1});
    wait_ack_drop();
    wait_cyc(t + 100);
    start_line(200, 1'b0, k);
    wait_drain();
    repeat (4) begin @(posedge clk); #1; end

    // reset mid-line with a CPU request pending
    start_line(0, 1'b1, t);
    wait_cyc(t + 50);
    rd_q.delete(); pix_q.delete(); ack_q.delete(); rdv_q.delete(); flag_q.delete();
    reset    = 1'b1;
    cpu_req  = 1'b1;
    cpu_addr = AW'(77);
    for (int i = 0; i < 3; i++) flag_q.push_back('{t + 50 + i, 4});
    flag_q.push_back('{t + 53, 0});
    ack_q.push_back('{t + 53, 77});
    rd_ins(t + 53, 77);
    rdv_q.push_back('{t + 55, 8'h5A});
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b0;
    wait_ack_drop();
    wait_drain();
    repeat (4) begin @(posedge clk); #1; end

    // a fresh line after reset behaves normally
    start_line(0, 1'b1, t);
    flag_q.push_back('{t + 808, 2});
    flag_q.push_back('{t + 810, 0});
    wait_drain();
    repeat (3) begin @(posedge clk); #1; end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
